universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised WIDTH-bit universal register built on edge-triggered storage.
- Supports hold, parallel load, logical/arithmetic shifts and rotates.
- Adds a multi-cycle rotate sequencer with busy/done handshake.
- Provides true and complementary outputs (q/qb), as the single-bit storage elements in this lab set do; datapath building block for later lab designs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the sequencer rotate-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  command strobe; op is sampled only when en=1 and busy=0.
- op  input  3  command code (see Behaviour).
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial-in bit entering bit 0 on a left shift.
- sin_r  input  1  serial-in bit entering bit WIDTH-1 on a right shift.
- amt  input  AMT_W  rotate count for SEQ.
- dir  input  1  SEQ direction: 0 = rotate left, 1 = rotate right.
- q  output  WIDTH  register contents.
- qb  output  WIDTH  bitwise complement of q, always ~q.
- so_msb  output  1  q[WIDTH-1], combinational.
- so_lsb  output  1  q[0], combinational.
- busy  output  1  high while SEQ is rotating.
- done  output  1  one-cycle pulse when SEQ completes.

Behaviour:
- All state updates on the rising edge of clk; rst has priority over everything.
- Reset values: q=0, qb=all ones, busy=0, done=0, internal counter=0.
- States: IDLE, SEQ_RUN.
- In IDLE with en=1, op is decoded on the edge:
  - 000 HOLD: no change.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[W-2:0],sin_l}.
  - 011 SHR: q<={sin_r,q[W-1:1]}.
  - 100 ROTL: q<={q[W-2:0],q[W-1]}.
  - 101 ROTR: q<={q[0],q[W-1:1]}.
  - 110 ASHR: q<={q[W-1],q[W-1:1]}.
  - 111 SEQ: latch amt into counter and dir into an internal register. If amt>0, go to SEQ_RUN with busy=1 and q unchanged on this edge. If amt=0, stay in IDLE with q unchanged and done=1 for the next cycle; busy never rises.
- In IDLE with en=0: hold.
- Single-step ops (000-110) complete in 1 cycle; done is not asserted for them.
- SEQ_RUN, on each edge:
  - Rotate q one bit in the latched direction and decrement the counter.
  - When the counter reaches 0 on that edge: busy<=0, done<=1, return to IDLE.
  - amt=N gives busy high for exactly N cycles. Final q and done become visible after the same edge (the N-th edge after acceptance).
- While busy: en, op, d, amt and dir are ignored. No queueing; a command presented during busy is lost.
- done deasserts the cycle after it is asserted. A new command may be accepted in the same cycle that done is high, since busy=0.
- amt larger than WIDTH is legal and rotates literally amt times.
- Reset asserted mid-SEQ: sequence aborts and all reset values are applied on that edge.
- qb, so_msb and so_lsb are purely combinational from q, with no extra latency.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> q=0x00, qb=0xFF, busy=0, done=0.
- Load/shift: LOAD d=0xA5; SHL sin_l=1 -> q=0x4B; SHR sin_r=0 -> q=0x25; so_msb=0, so_lsb=1.
- Rotate/arith: LOAD 0x81; ROTL -> 0x03; ROTR -> 0x81; ASHR -> 0xC0; en=0 with op=LOAD d=0x00 -> q stays 0xC0.
- SEQ: LOAD 0x01; SEQ amt=3 dir=1 -> busy high 3 cycles, q steps 0x80, 0x40, 0x20. done pulses 1 cycle together with q=0x20. LOAD d=0xFF presented while busy is ignored.
- SEQ amt=0: q unchanged, busy stays 0, done high exactly 1 cycle after acceptance.
- Reset mid-SEQ: SEQ amt=5 on 0x01, assert rst on the 2nd busy cycle -> q=0, busy=0, done=0 next cycle, no done pulse afterwards.

Source files
------------

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, load, shifts, rotates, and a multi-cycle
// rotate sequencer with busy/done handshake. qb/so_msb/so_lsb derive directly from q.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StSeqRun} state_e;

  localparam logic [2:0] OpHold = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpShl  = 3'b010;
  localparam logic [2:0] OpShr  = 3'b011;
  localparam logic [2:0] OpRotl = 3'b100;
  localparam logic [2:0] OpRotr = 3'b101;
  localparam logic [2:0] OpAshr = 3'b110;
  localparam logic [2:0] OpSeq  = 3'b111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      reg_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          unique case (op)
            OpHold: reg_d = reg_q;
            OpLoad: reg_d = d;
            OpShl:  reg_d = {reg_q[WIDTH-2:0], sin_l};
            OpShr:  reg_d = {sin_r, reg_q[WIDTH-1:1]};
            OpRotl: reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
            OpRotr: reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
            OpAshr: reg_d = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
            OpSeq: begin
              cnt_d = amt;
              dir_d = dir;
              // A zero count completes immediately without ever raising busy.
              if (amt != '0) begin
                state_d = StSeqRun;
              end else begin
                done_d = 1'b1;
              end
            end
            default: reg_d = reg_q;
          endcase
        end
      end
      StSeqRun: begin
        reg_d = dir_q ? {reg_q[0], reg_q[WIDTH-1:1]} : {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign q      = reg_q;
  assign qb     = ~reg_q;
  assign so_msb = reg_q[WIDTH-1];
  assign so_lsb = reg_q[0];
  assign busy   = (state_q == StSeqRun);
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: driver pushes model predictions,
// monitor pops and compares one entry per cycle.
module tb_universal_shift_reg;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 4;
  localparam int unsigned MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, en, sin_l, sin_r, dir;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] q, qb;
  logic             so_msb, so_lsb, busy, done;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .amt(amt), .dir(dir), .q(q), .qb(qb), .so_msb(so_msb), .so_lsb(so_lsb),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: value as a plain integer, remaining rotations as a count.
  int unsigned m_val   = 0;
  int          m_left  = 0;
  logic        m_right = 1'b0;
  logic        m_done  = 1'b0;

  function automatic int unsigned rot1(input int unsigned v, input logic right);
    if (right) return ((v >> 1) | ((v & 1) << (WIDTH - 1))) & MASK;
    return ((v << 1) | (v >> (WIDTH - 1))) & MASK;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("q", q, e.q);
      check("qb", qb, ~e.q);
      check("so_msb", WIDTH'(so_msb), WIDTH'(e.q[WIDTH-1]));
      check("so_lsb", WIDTH'(so_lsb), WIDTH'(e.q[0]));
      check("busy", WIDTH'(busy), WIDTH'(e.busy));
      check("done", WIDTH'(done), WIDTH'(e.done));
    end
  end

  task automatic step(input logic i_rst, input logic i_en, input logic [2:0] i_op,
                      input logic [WIDTH-1:0] i_d, input logic i_sl, input logic i_sr,
                      input logic [AMT_W-1:0] i_amt, input logic i_dir);
    exp_t e;
    int unsigned dv;
    @(negedge clk);
    #1;
    rst = i_rst; en = i_en; op = i_op; d = i_d;
    sin_l = i_sl; sin_r = i_sr; amt = i_amt; dir = i_dir;
    dv = i_d;
    if (i_rst) begin
      m_val = 0; m_left = 0; m_done = 1'b0; m_right = 1'b0;
    end else if (m_left > 0) begin
      m_val  = rot1(m_val, m_right);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (i_en) begin
        case (i_op)
          3'd1: m_val = dv;
          3'd2: m_val = ((m_val << 1) | i_sl) & MASK;
          3'd3: m_val = (m_val >> 1) | (int'(i_sr) << (WIDTH - 1));
          3'd4: m_val = rot1(m_val, 1'b0);
          3'd5: m_val = rot1(m_val, 1'b1);
          3'd6: m_val = (m_val >> 1) | (m_val & (1 << (WIDTH - 1)));
          3'd7: begin
            if (i_amt == 0) m_done = 1'b1;
            else begin
              m_left  = int'(i_amt);
              m_right = i_dir;
            end
          end
          default: ;
        endcase
      end
    end
    e.q    = m_val[WIDTH-1:0];
    e.busy = (m_left > 0);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [WIDTH-1:0] v, input logic sl,
                     input logic sr, input logic [AMT_W-1:0] a, input logic dr);
    step(1'b0, 1'b1, c, v, sl, sr, a, dr);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; en = 1'b0; op = '0; d = '0; sin_l = 1'b0; sin_r = 1'b0; amt = '0; dir = 1'b0;
    // Reset with arbitrary inputs
    step(1'b1, 1'b1, 3'd1, 8'h5A, 1'b1, 1'b1, 4'd7, 1'b1);
    step(1'b1, 1'b1, 3'd7, 8'h3C, 1'b0, 1'b1, 4'd2, 1'b0);
    // Load / shift
    cmd(3'd1, 8'hA5, 1'b0, 1'b0, '0, 1'b0);
    cmd(3'd2, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    cmd(3'd3, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    // Rotate / arithmetic / en=0 hold
    cmd(3'd1, 8'h81, 1'b0, 1'b0, '0, 1'b0);
    cmd(3'd4, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    cmd(3'd5, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    cmd(3'd6, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    // SEQ right by 3 with a LOAD attempted while busy
    cmd(3'd1, 8'h01, 1'b0, 1'b0, '0, 1'b0);
    cmd(3'd7, 8'h00, 1'b0, 1'b0, 4'd3, 1'b1);
    cmd(3'd1, 8'hFF, 1'b0, 1'b0, '0, 1'b0);
    idle(); idle(); idle();
    // SEQ amt=0
    cmd(3'd7, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(); idle();
    // Reset on the 2nd busy cycle of a 5-step sequence
    cmd(3'd1, 8'h01, 1'b0, 1'b0, '0, 1'b0);
    cmd(3'd7, 8'h00, 1'b0, 1'b0, 4'd5, 1'b0);
    idle();
    step(1'b0 | 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (6) idle();
    // Randomized traffic, including back-to-back SEQ on the done cycle
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      step(r[5:0] == 6'd0, r[6] | r[7], r[10:8], r[18:11], r[19], r[20], r[24:21], r[25]);
    end
    repeat (20) idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
